alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational execute-stage ALU.
- Registers every result and adds OR, logical shifts, signed/unsigned compare and an iterative shift-add multiplier.
- Sits between decode/issue and writeback, with valid/ready on both sides.
- Op codes 1-5 keep the legacy 3-bit encoding, zero-extended.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for the sequential ALU.
// The slave modport is the ALU side; the master modport is the issuing/consuming side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_operand0;
    logic [WIDTH-1:0] i_operand1;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_err;
    logic             o_busy;

    modport slave (
        input  i_valid, i_op, i_operand0, i_operand1, i_ready,
        output o_ready, o_valid, o_result, o_err, o_busy
    );

    modport master (
        output i_valid, i_op, i_operand0, i_operand1, i_ready,
        input  o_ready, o_valid, o_result, o_err, o_busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked execute-stage ALU with an iterative shift-add multiplier.
// Single-cycle ops land in DONE one edge after accept; MUL spends WIDTH cycles in BUSY.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      i_clk,
    input logic      i_rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_sum;
    logic [SHW-1:0]   count;
    logic             ready, accept, is_mul;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [SHW-1:0]   shamt;

    assign ready  = (state == IDLE) || (state == DONE && bus.i_ready);
    assign accept = bus.i_valid && ready;
    assign is_mul = (bus.i_op == OP_MUL);
    assign shamt  = bus.i_operand1[SHW-1:0];

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    assign bus.o_ready  = ready;
    assign bus.o_valid  = (state == DONE);
    assign bus.o_busy   = (state == BUSY);
    assign bus.o_result = result_q;
    assign bus.o_err    = err_q;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.i_op)
            OP_ADD:  alu_res = bus.i_operand0 + bus.i_operand1;
            OP_SUB:  alu_res = bus.i_operand0 - bus.i_operand1;
            OP_XOR:  alu_res = bus.i_operand0 ^ bus.i_operand1;
            OP_AND:  alu_res = bus.i_operand0 & bus.i_operand1;
            OP_SRA:  alu_res = $unsigned($signed(bus.i_operand0) >>> shamt);
            OP_OR:   alu_res = bus.i_operand0 | bus.i_operand1;
            OP_SLL:  alu_res = bus.i_operand0 << shamt;
            OP_SRL:  alu_res = bus.i_operand0 >> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.i_operand0) < $signed(bus.i_operand1))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.i_operand0 < bus.i_operand1)};
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_mul ? BUSY : DONE;
            BUSY: if (count == '0) state_next = DONE;
            DONE: begin
                if (bus.i_ready) begin
                    if (accept) state_next = is_mul ? BUSY : DONE;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The final multiply step writes acc_sum straight into the result so DONE shows the full product.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (is_mul) begin
                    acc    <= '0;
                    mcand  <= bus.i_operand0;
                    mplier <= bus.i_operand1;
                    count  <= SHW'(WIDTH - 1);
                end else begin
                    result_q <= alu_res;
                    err_q    <= alu_err;
                end
            end
            if (state == BUSY) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
                if (count == '0) begin
                    result_q <= acc_sum;
                    err_q    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_op       = op;
        bus.i_operand0 = a;
        bus.i_operand1 = b;
        bus.i_valid    = 1'b1;
    endtask

    // One isolated op: accept, check result in DONE, drain back to IDLE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
        bus.i_ready = 1'b1;
        apply_stimulus(op, a, b);
        tick();
        bus.i_valid = 1'b0;
        check_output({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check_output({tag, "_result"}, bus.o_result, exp_res);
        check_output({tag, "_err"}, 32'(bus.o_err), 32'(exp_err));
        tick();
        check_output({tag, "_drain"}, 32'(bus.o_valid), 32'd0);
    endtask

    initial begin
        int          cycles;
        logic        ready_seen;
        logic [31:0] held;

        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b1;
        bus.i_op       = 4'd0;
        bus.i_operand0 = '0;
        bus.i_operand1 = '0;
        tick();
        tick();
        check_output("rst_valid", 32'(bus.o_valid), 32'd0);
        check_output("rst_result", bus.o_result, 32'd0);
        check_output("rst_err", 32'(bus.o_err), 32'd0);
        check_output("rst_busy", 32'(bus.o_busy), 32'd0);
        check_output("rst_ready", 32'(bus.o_ready), 32'd1);
        rst_n = 1'b1;

        run_op("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0);
        check_output("idle_ready", 32'(bus.o_ready), 32'd1);
        run_op("sub_wrap", 4'd2, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run_op("and", 4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        run_op("sra", 4'd5, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0);
        run_op("srl", 4'd8, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0);
        run_op("sll", 4'd7, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
        run_op("slt", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        run_op("sltu", 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_op("illegal_f", 4'hF, 32'h1234_5678, 32'd1, 32'd0, 1'b1);
        run_op("illegal_0", 4'h0, 32'h1234_5678, 32'd1, 32'd0, 1'b1);

        // Streamed SUB, XOR, OR with both sides always ready.
        bus.i_ready = 1'b1;
        apply_stimulus(4'd2, 32'd10, 32'd3);
        check_output("stream_rdy0", 32'(bus.o_ready), 32'd1);
        tick();
        check_output("stream_v0", 32'(bus.o_valid), 32'd1);
        check_output("stream_r0", bus.o_result, 32'd7);
        apply_stimulus(4'd3, 32'h0000_F0F0, 32'h0000_FF00);
        check_output("stream_rdy1", 32'(bus.o_ready), 32'd1);
        tick();
        check_output("stream_v1", 32'(bus.o_valid), 32'd1);
        check_output("stream_r1", bus.o_result, 32'h0000_0FF0);
        apply_stimulus(4'd6, 32'h0000_1200, 32'h0000_0034);
        check_output("stream_rdy2", 32'(bus.o_ready), 32'd1);
        tick();
        check_output("stream_v2", 32'(bus.o_valid), 32'd1);
        check_output("stream_r2", bus.o_result, 32'h0000_1234);
        bus.i_valid = 1'b0;
        tick();
        check_output("stream_end", 32'(bus.o_valid), 32'd0);

        // Multiply with a stalled consumer.
        apply_stimulus(4'd11, 32'h0001_0003, 32'h0000_0005);
        tick();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        cycles      = 0;
        ready_seen  = 1'b0;
        while (bus.o_busy === 1'b1 && cycles < 100) begin
            if (bus.o_ready !== 1'b0) ready_seen = 1'b1;
            cycles++;
            tick();
        end
        check_output("mul_busy_cycles", 32'(cycles), 32'd32);
        check_output("mul_ready_low", 32'(ready_seen), 32'd0);
        check_output("mul_valid", 32'(bus.o_valid), 32'd1);
        check_output("mul_result", bus.o_result, 32'h0005_000F);
        check_output("mul_err", 32'(bus.o_err), 32'd0);
        held = bus.o_result;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("mul_hold_valid", 32'(bus.o_valid), 32'd1);
            check_output("mul_hold_result", bus.o_result, held);
        end
        bus.i_ready = 1'b1;
        tick();
        check_output("mul_drain", 32'(bus.o_valid), 32'd0);

        // Reset in the middle of a multiply must abort it cleanly.
        apply_stimulus(4'd11, 32'd7, 32'd9);
        tick();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_output("abort_busy_before", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output("abort_valid", 32'(bus.o_valid), 32'd0);
        check_output("abort_busy", 32'(bus.o_busy), 32'd0);
        check_output("abort_ready", 32'(bus.o_ready), 32'd1);
        run_op("post_abort_add", 4'd1, 32'd2, 32'd3, 32'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
